// File: rtl/framebuffer_writer_pkg.sv
// Shared constants, FSM encoding and the frame-buffer address helper.
package framebuffer_writer_pkg;

  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int FB_ADDR_W = 17;
  localparam int COLOR_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // y*320 + x as (y<<8) + (y<<6) + x, so no multiplier is needed
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [8:0] x, input logic [7:0] y);
    return {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
  endfunction

endpackage

// File: rtl/framebuffer_writer_pixel_fifo.sv
// Small synchronous FIFO holding {addr, color} pixel entries.
module framebuffer_writer_pixel_fifo
  import framebuffer_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FB_ADDR_W + COLOR_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_count == FULL_CNT);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  // pointer update; reset discards any queued entries
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // storage array, no reset needed since empty flag gates reads
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel sink: clips, queues and writes pixels to the frame RAM, plus full-screen clear.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [8:0]  pix_x,
  input  logic [7:0]  pix_y,
  input  logic [2:0]  pix_color,
  input  logic        pix_we,
  output logic        pix_ready,
  input  logic        clear_start,
  input  logic [2:0]  clear_color,
  output logic        clear_done,
  output logic        busy,
  input  logic        disp_req,
  output logic [16:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  output logic [15:0] drop_count
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = FB_ADDR_W + COLOR_W;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_in_bounds;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_sweep_en;
  logic                 w_last_sweep;
  logic                 w_pix_ready;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic [CNT_W-1:0]     w_count_next;
  logic [ENTRY_W-1:0]   w_fifo_dout;
  logic [FB_ADDR_W-1:0] r_sweep;
  logic [FB_ADDR_W-1:0] r_mem_addr;
  logic [COLOR_W-1:0]   r_mem_data;
  logic [COLOR_W-1:0]   r_clear_color;
  logic                 r_mem_we;
  logic                 r_last_wr;
  logic                 r_clear_done;
  logic                 r_busy;
  logic [15:0]          r_drop_count;

  // off-screen pixels are still handshaken so the renderer never stalls on them
  assign w_in_bounds  = (int'(pix_x) < SCREEN_W) && (int'(pix_y) < SCREEN_H);
  assign w_accept     = pix_we && w_pix_ready;
  assign w_push       = w_accept && w_in_bounds;
  assign w_last_sweep = w_sweep_en && (r_sweep == LAST_ADDR);
  assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  framebuffer_writer_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_pixel_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({fb_addr(pix_x, pix_y), pix_color}),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // next-state logic; a pixel pushed alongside clear_start must drain first
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (clear_start) w_state_next = (!w_empty || w_push) ? DRAIN : CLEAR;
      DRAIN:   if (w_count_next == '0) w_state_next = CLEAR;
      CLEAR:   if (w_last_sweep) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // per-state controls: input handshake, FIFO pop, sweep write enable
  always_comb begin
    w_pix_ready = 1'b0;
    w_pop       = 1'b0;
    w_sweep_en  = 1'b0;
    case (r_state)
      IDLE: begin
        w_pix_ready = !w_full;
        w_pop       = !w_empty && !disp_req;
      end
      DRAIN:   w_pop      = !w_empty && !disp_req;
      CLEAR:   w_sweep_en = !disp_req;
      default: ;
    endcase
  end

  // RAM write port: FIFO head or sweep address, idle while display owns the port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_pop) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= w_fifo_dout[ENTRY_W-1:COLOR_W];
        r_mem_data <= w_fifo_dout[COLOR_W-1:0];
      end else if (w_sweep_en) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= r_sweep;
        r_mem_data <= r_clear_color;
      end
    end
  end

  // sweep counter restarts at zero every time CLEAR is entered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               r_sweep <= '0;
    else if (r_state != CLEAR) r_sweep <= '0;
    else if (w_sweep_en)       r_sweep <= r_sweep + 1'b1;
  end

  // clear colour latch, done pulse one edge after the final write and busy flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clear_color <= '0;
      r_last_wr     <= 1'b0;
      r_clear_done  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (r_state == IDLE && clear_start) r_clear_color <= clear_color;
      r_last_wr    <= w_last_sweep;
      r_clear_done <= r_last_wr;
      r_busy       <= (w_state_next != IDLE) || (w_count_next != '0);
    end
  end

  // saturating count of clipped pixels
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_drop_count <= '0;
    else if (w_accept && !w_in_bounds && r_drop_count != 16'hFFFF)
      r_drop_count <= r_drop_count + 16'd1;
  end

  assign pix_ready  = w_pix_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign clear_done = r_clear_done;
  assign busy       = r_busy;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  pix_x = '0;
  logic [7:0]  pix_y = '0;
  logic [2:0]  pix_color = '0;
  logic        pix_we = 1'b0;
  logic        pix_ready;
  logic        clear_start = 1'b0;
  logic [2:0]  clear_color = '0;
  logic        clear_done;
  logic        busy;
  logic        disp_req = 1'b0;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  // reference model: queue of pending {addr,color} writes and drop counter
  logic [19:0] mq[$];
  logic [15:0] mdrop = '0;

  framebuffer_writer #(
    .FIFO_DEPTH (DEPTH),
    .SCREEN_W   (320),
    .SCREEN_H   (240)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .pix_we      (pix_we),
    .pix_ready   (pix_ready),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_done  (clear_done),
    .busy        (busy),
    .disp_req    (disp_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input int x, input int y, input int c, input logic dr);
    pix_we    = we;
    pix_x     = 9'(x);
    pix_y     = 8'(y);
    pix_color = 3'(c);
    disp_req  = dr;
  endtask

  // one idle-mode cycle: called at a negedge with inputs already driven
  task automatic step(output logic acc);
    logic        exp_ready;
    logic        pop_now;
    logic [19:0] popped;
    int          a;
    exp_ready = (mq.size() < DEPTH);
    chk("pix_ready", pix_ready, exp_ready);
    pop_now = (mq.size() > 0) && !disp_req;
    popped  = '0;
    if (pop_now) popped = mq.pop_front();
    acc = pix_we && exp_ready;
    if (acc) begin
      if (pix_x < 320 && pix_y < 240) begin
        a = int'(pix_y) * 320 + int'(pix_x);
        mq.push_back({17'(a), pix_color});
      end else if (mdrop != 16'hFFFF) begin
        mdrop++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("mem_we", mem_we, pop_now);
    if (pop_now) begin
      chk("mem_addr", mem_addr, popped[19:3]);
      chk("mem_data", mem_data, popped[2:0]);
    end
    chk("drop_count", drop_count, mdrop);
    chk("busy", busy, mq.size() != 0);
  endtask

  initial begin
    logic        acc;
    logic        acc_seen;
    logic        reached;
    logic        prev_dr;
    logic        last_seen;
    logic [19:0] e;
    int          idx;
    int          done_cnt;
    int          last_cyc;
    int          done_cyc;

    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pix_x = 9'($urandom); pix_y = 8'($urandom); pix_color = 3'($urandom);
      pix_we = 1'($urandom); clear_start = 1'($urandom); disp_req = 1'($urandom);
      clear_color = 3'($urandom);
      #1;
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_ready", pix_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", clear_done, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    clear_start = 0;
    resetn = 1;
    mq.delete();
    mdrop = '0;

    // single pixel, expect write of 1610/5 two edges after acceptance
    drive(1, 10, 5, 5, 0); step(acc);
    drive(0, 0, 0, 0, 0);  step(acc);
    step(acc);

    // display holds the port: four fill the FIFO, the fifth waits
    for (int i = 0; i < 5; i++) begin
      drive(1, 20 + i, 7, i + 1, 1); step(acc);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 24, 7, 5, 1); step(acc);
    end
    acc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (acc_seen) drive(0, 0, 0, 0, 0);
      else          drive(1, 24, 7, 5, 0);
      step(acc);
      if (acc) acc_seen = 1;
    end
    chk("fifth_accepted", acc_seen, 1);

    // clipping boundaries
    drive(1, 0, 240, 1, 0);   step(acc);
    drive(1, 319, 239, 6, 0); step(acc);
    drive(1, 320, 0, 1, 0);   step(acc);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(acc);

    // randomized traffic in idle mode
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 335), $urandom_range(0, 250),
            $urandom_range(0, 7), $urandom_range(0, 3) == 0);
      step(acc);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(acc);

    // clear with two pixels queued behind a held display request
    drive(1, 100, 50, 3, 1); step(acc);
    drive(1, 101, 50, 4, 1); step(acc);
    drive(0, 0, 0, 0, 0);
    clear_start = 1;
    clear_color = 3'd2;
    idx = 0; done_cnt = 0; last_cyc = -1; done_cyc = -1; last_seen = 0;
    for (int cyc = 0; cyc < 90000; cyc++) begin
      if (cyc > 0) begin
        clear_start = 0;
        clear_color = 3'd7;
        disp_req = (cyc < 3000) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      prev_dr = disp_req;
      @(posedge clk);
      @(negedge clk);
      if (prev_dr) chk("clr_disp_blocks", mem_we, 0);
      if (mem_we) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          chk("drain_addr", mem_addr, e[19:3]);
          chk("drain_data", mem_data, e[2:0]);
        end else begin
          chk("clr_addr", mem_addr, idx);
          chk("clr_data", mem_data, 2);
          idx++;
          if (idx == 76800) begin
            last_seen = 1;
            last_cyc  = cyc;
          end
        end
      end
      if (!last_seen) begin
        chk("clr_ready_low", pix_ready, 0);
        chk("clr_busy", busy, 1);
      end
      if (clear_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (last_seen && cyc >= last_cyc + 3) break;
    end
    chk("clr_all_written", idx, 76800);
    chk("clr_done_once", done_cnt, 1);
    chk("clr_done_timing", done_cyc, last_cyc + 1);
    chk("clr_busy_after", busy, 0);
    chk("clr_ready_after", pix_ready, 1);
    chk("clr_drop_kept", drop_count, mdrop);

    // reset in the middle of a clear sweep
    drive(0, 0, 0, 0, 0);
    clear_start = 1;
    clear_color = 3'd5;
    reached = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      @(negedge clk);
      clear_start = 0;
      if (mem_we && mem_addr >= 17'd1000) begin
        reached = 1;
        break;
      end
    end
    chk("reach_1000", reached, 1);
    #2 resetn = 0;
    #1;
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", pix_ready, 1);
    chk("mid_rst_drop", drop_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", clear_done, 0);
      chk("mid_rst_no_we", mem_we, 0);
    end
    @(negedge clk);
    resetn = 1;
    mq.delete();
    mdrop = '0;
    for (int i = 0; i < 5; i++) step(acc);
    drive(1, 7, 3, 6, 0); step(acc);
    drive(0, 0, 0, 0, 0);
    step(acc);
    step(acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Pixel sink on the far end of the rectangle renderer's pixel stream. Accepts (x, y, color, write-enable) pixels and clips those outside the 320x240 screen. Buffers accepted pixels in a small FIFO and writes them into the single-port 3-bit frame RAM, yielding the RAM port to the display scan-out whenever it requests it. Also provides a full-screen clear sweep.

## Interface
Parameters:
- FIFO_DEPTH, 4, pixel FIFO entries (power of two, ≥2)
- SCREEN_W, 320, screen width in pixels
- SCREEN_H, 240, screen height in pixels

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous, active-low reset
- pix_x  in  9  pixel x coordinate
- pix_y  in  8  pixel y coordinate
- pix_color  in  3  pixel color
- pix_we  in  1  pixel valid, active high
- pix_ready  out  1  sink can accept a pixel this cycle
- clear_start  in  1  request full-screen clear (sampled each edge)
- clear_color  in  3  fill color, sampled when clear is accepted
- clear_done  out  1  one-cycle pulse after last clear write
- busy  out  1  FIFO non-empty or drain/clear in progress
- disp_req  in  1  display owns the RAM port this cycle; no write may issue
- mem_addr  out  17  frame RAM write address
- mem_data  out  3  frame RAM write data
- mem_we  out  1  frame RAM write enable
- drop_count  out  16  count of clipped pixels, saturating at 16'hFFFF

## Operation
- A pixel transfers on a rising edge with pix_we && pix_ready. pix_ready = !fifo_full && state==IDLE (combinational).
- Clipping at acceptance: pixels with x ≥ SCREEN_W or y ≥ SCREEN_H are accepted but not enqueued. drop_count increments by 1, saturating.
- Address = y*320 + x, computed as (y<<8)+(y<<6)+x, 17 bits. Maximum 76799.
- FSM states:
  - IDLE: pops the FIFO head whenever the FIFO is non-empty and !disp_req. The pop registers mem_addr/mem_data and sets mem_we=1 for one cycle.
  - On clear_start in IDLE: latch clear_color. Go to DRAIN if the FIFO is non-empty, else CLEAR.
  - DRAIN: pix_ready=0. Keeps popping and writing as in IDLE. Moves to CLEAR when the FIFO becomes empty.
  - CLEAR: pix_ready=0. A 17-bit sweep counter starts at 0. On each edge with !disp_req, it writes the latched color at the counter value and increments. After writing 76799, the block pulses clear_done and returns to IDLE.
- clear_start is ignored in DRAIN and CLEAR.
- disp_req high: mem_we=0 next cycle. FIFO and sweep counter hold, no data lost.
- Push when full is impossible (pix_ready low). Simultaneous push and pop on a non-full FIFO is legal; occupancy is unchanged.
- Writes leave the FIFO strictly in FIFO order.

## Timing
- Reset values (immediate on resetn low, asynchronous):
  - state=IDLE, FIFO empty
  - mem_we=0, mem_addr=0, mem_data=0
  - drop_count=0, clear_done=0, busy=0
  - pix_ready=1
- Latency: pixel accepted at edge N into an empty FIFO with disp_req low → mem_we=1 during the cycle after edge N+1.
- Throughput: one RAM write per cycle when disp_req is low.
- A full clear with no disp_req takes 76800 cycles of mem_we=1. clear_done rises on the edge after the write of address 76799.
- resetn asserted mid-drain or mid-clear: the operation is abandoned and FIFO contents are discarded. Nothing resumes after reset.
- busy is registered and valid on the same edge the state/FIFO changes.

## Structure
- Shared package holds the constants SCREEN_W=320, SCREEN_H=240, FB_ADDR_W=17, COLOR_W=3, plus the FSM state encoding (IDLE, DRAIN, CLEAR).
- One sub-module, pixel_fifo: synchronous FIFO of {addr[16:0], color[2:0]} entries, with full/empty flags and async active-low reset.
- The address multiply happens before the push, so FIFO entries store the address, not x/y.
- The existing counter module is not reused; the sweep counter is inline.

## Test plan
- Reset: hold resetn=0 with random inputs → mem_we=0, mem_addr=0, drop_count=0, pix_ready=1, busy=0.
- Single pixel (x=10, y=5, color=3'b101), disp_req=0 → exactly one mem_we pulse two edges later, with mem_addr=1610, mem_data=5.
- disp_req held high, stream 5 pixels → 4 accepted, pix_ready low on the 5th, mem_we stays 0. On release → 4 consecutive writes in input order, then the 5th is accepted.
- Clipping: pixel (x=0, y=240) → no write, drop_count=1. Pixel (x=319, y=239) → write at mem_addr=76799.
- clear_start with 2 pixels queued and clear_color=3'b010 → the 2 pixel writes first, then addresses 0..76799 with data 2. pix_ready=0 throughout. clear_done pulses once. Toggling disp_req inserts gaps without skipped addresses.
- resetn pulsed low mid-clear (at address ~1000) → mem_we=0 immediately, no clear_done. Afterwards a new pixel writes normally.
